// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks the PC, issues one-cycle-latency text-memory reads and
// buffers {pc, inst} pairs for decode; redirect flushes everything and restarts fetch.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      mem_req,
    output logic [15:0]               mem_addr,
    input  logic [15:0]               mem_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               out_inst,
    output logic [15:0]               out_pc,
    input  logic                      redirect,
    input  logic [15:0]               redirect_pc,
    input  logic                      halt,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic          infl_q, infl_d;
    logic [15:0]   infl_addr_q, infl_addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   fifo_pc_q   [DEPTH];
    logic [15:0]   fifo_inst_q [DEPTH];

    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          push;
    logic          pop;

    // The in-flight read already owns a slot, so it is counted against the credit.
    assign occupancy = {1'b0, count_q} + (CW+1)'(infl_q);
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    assign mem_req   = reset & ~halt & ~redirect & credit_ok;
    assign mem_addr  = mem_req ? fetch_pc_q : 16'h0000;
    assign out_valid = (count_q != '0);
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign out_inst  = fifo_inst_q[rd_ptr_q];
    assign count     = count_q;

    assign push = infl_q & ~redirect;
    assign pop  = out_valid & out_ready;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        infl_d      = mem_req;
        infl_addr_d = infl_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (mem_req) begin
                infl_addr_d = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + 16'd1;
            end
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            infl_q      <= 1'b0;
            infl_addr_q <= 16'h0000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= 16'h0000;
                fifo_inst_q[i] <= 16'h0000;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]   <= infl_addr_q;
            fifo_inst_q[wr_ptr_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed phases plus random traffic, checked every cycle against
// a queue-based reference model; a second instance checks PC wrap from RESET_PC=16'hFFFE.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, out_valid, out_ready, redirect, halt;
    logic [15:0] mem_addr, mem_data, out_inst, out_pc, redirect_pc;
    logic [2:0]  count;

    logic        mem_req2, out_valid2;
    logic        out_ready2 = 1'b1, redirect2 = 1'b0, halt2 = 1'b0;
    logic [15:0] mem_addr2, mem_data2, out_inst2, out_pc2;
    logic [15:0] redirect_pc2 = 16'h0000;
    logic [2:0]  count2;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] mq[$];
    bit          m_infl;
    logic [15:0] m_infl_addr;
    logic [15:0] m_pc;
    int          cyc;
    bit          p2_req;
    logic [15:0] p2_addr;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .count(count)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_data(mem_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_inst(out_inst2), .out_pc(out_pc2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .halt(halt2), .count(count2)
    );

    function automatic logic [15:0] word(input logic [15:0] a);
        return a + 16'hA000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst",  out_inst,  0);
        chk("rst_out_pc",    out_pc,    0);
        chk("rst_count",     count,     0);
        chk("rst2_mem_req",  mem_req2,  0);
        chk("rst2_out_pc",   out_pc2,   0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl      = 1'b0;
        m_infl_addr = 16'h0000;
        m_pc        = 16'h0000;
        cyc         = 0;
        p2_req      = 1'b0;
        p2_addr     = 16'h0000;
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input bit rdy, input bit rdr, input logic [15:0] rpc, input bit hlt);
        bit          e_req;
        logic [15:0] e2_pc;
        out_ready   = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        halt        = hlt;
        mem_data    = m_infl ? word(m_infl_addr) : 16'($urandom);
        mem_data2   = p2_req ? word(p2_addr) : 16'($urandom);
        @(negedge clk);
        e_req = !hlt && !rdr && ((mq.size() + int'(m_infl)) < DEPTH);
        chk("mem_req", mem_req, e_req);
        if (e_req) chk("mem_addr", mem_addr, m_pc);
        chk("count", count, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_inst", out_inst, word(mq[0]));
        end
        if (cyc == 0) begin
            chk("wrap_first_req", mem_req2, 1);
            chk("wrap_first_addr", mem_addr2, 16'hFFFE);
        end
        if (cyc >= 2 && cyc < 8) begin
            e2_pc = 16'hFFFE + 16'(cyc - 2);
            chk("wrap_out_valid", out_valid2, 1);
            chk("wrap_out_pc", out_pc2, e2_pc);
            chk("wrap_out_inst", out_inst2, word(e2_pc));
        end
        p2_req  = mem_req2;
        p2_addr = mem_addr2;
        if (rdr) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = rpc;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_addr);
            m_infl = e_req;
            if (e_req) begin
                m_infl_addr = m_pc;
                m_pc        = m_pc + 16'd1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        mem_data    = 16'h0000;
        mem_data2   = 16'h0000;
        #2;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming with decode always ready.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);

        // Decode stalls: queue fills to DEPTH and fetch stops, then drains in order.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 16'h0000, 1'b0);

        // Redirect with three queued entries and one read in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);

        // Halt pulse mid-stream.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);

        // Redirect near the top of the address space, then reset with a read in flight.
        step(1'b1, 1'b1, 16'hFFFD, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0000, 1'b0);
        do_reset();

        // Random traffic, including one reset part way through.
        for (int i = 0; i < 500; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                              : 16'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc,
                 $urandom_range(0, 9) == 0);
            if (i == 250) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
